// File: rtl/x_multdiv_ctrl_if.sv
// D/X-to-execute mul/div bundle: instruction and operands in, stall and result out.
// Combinational bundle, no latency; stall is the only backpressure and is driven by the slave.
// The master holds the D/X contents steady while stall is high.
interface x_multdiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] instruction_in;
  logic [WIDTH-1:0] data_inA;
  logic [WIDTH-1:0] data_inB;
  logic             flush;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_rdy;
  logic             exception;

  modport master (
    output instruction_in, data_inA, data_inB, flush,
    input  stall, result, result_rdy, exception
  );

  modport slave (
    input  instruction_in, data_inA, data_inB, flush,
    output stall, result, result_rdy, exception
  );
endinterface

// File: rtl/x_multdiv_ctrl.sv
// Iterative signed 32-bit multiply / restoring divide driven from the D/X latch.
// Latency: 1 IDLE + ITER RUN stall cycles, then one DONE cycle with result_rdy.
// Backpressure: stall holds D/X for the whole operation; flush aborts, reset aborts at once.
module x_multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic              clk,
  input  logic              reset,
  x_multdiv_ctrl_if.slave   bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] opReg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             opDiv;
  logic             negRes;
  logic [WIDTH-1:0] resultReg;
  logic             excReg;

  // Decode of the instruction currently held at the D/X outputs
  logic isMd;
  logic isDivIn;
  assign isMd    = (bus.instruction_in[31:27] == 5'b00000) &&
                   (bus.instruction_in[6:3] == 4'b0011);
  assign isDivIn = bus.instruction_in[2];

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  assign absA = bus.data_inA[WIDTH-1] ? (~bus.data_inA + 1'b1) : bus.data_inA;
  assign absB = bus.data_inB[WIDTH-1] ? (~bus.data_inB + 1'b1) : bus.data_inB;

  logic lastIter;
  logic start;
  logic finish;
  assign lastIter = (counter == CW'(ITER - 1));
  assign start    = (state == IDLE) && isMd && !bus.flush;
  assign finish   = (state == RUN) && lastIter && !bus.flush;

  // One iteration step. Multiply: opReg is |A|, {hi,lo} shifts right as the
  // product accumulates. Divide: opReg is |B|, hi is the remainder and lo
  // shifts the dividend out while quotient bits shift in.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divSub;
  logic             divGe;
  logic [WIDTH-1:0] hiStep;
  logic [WIDTH-1:0] loStep;

  always_comb begin
    mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, opReg} : '0);
    divShift = {hi, lo[WIDTH-1]};
    divGe    = (divShift >= {1'b0, opReg});
    divSub   = divShift[WIDTH-1:0] - opReg;
    if (opDiv) begin
      hiStep = divGe ? divSub : divShift[WIDTH-1:0];
      loStep = {lo[WIDTH-2:0], divGe};
    end else begin
      hiStep = mulSum[WIDTH:1];
      loStep = {mulSum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign correction and exception on the final step's values
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodSigned;
  logic [WIDTH-1:0]   quotSigned;
  logic               mulExc;
  logic               divZero;
  logic               divOvf;
  logic [WIDTH-1:0]   finalRes;
  logic               finalExc;

  always_comb begin
    prodMag    = {hiStep, loStep};
    prodSigned = negRes ? (~prodMag + 1'b1) : prodMag;
    quotSigned = negRes ? (~loStep + 1'b1) : loStep;
    mulExc     = !((&prodSigned[2*WIDTH-1:WIDTH-1]) || !(|prodSigned[2*WIDTH-1:WIDTH-1]));
    divZero    = (opReg == '0);
    // Only |MIN|/1 with a positive sign yields a magnitude that does not fit
    divOvf     = !negRes && loStep[WIDTH-1];
    finalRes   = '0;
    finalExc   = 1'b0;
    if (!opDiv) begin
      finalRes = prodSigned[WIDTH-1:0];
      finalExc = mulExc;
    end else if (divZero) begin
      finalRes = '0;
      finalExc = 1'b1;
    end else begin
      finalRes = quotSigned;
      finalExc = divOvf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  logic stallC;
  logic rdyC;

  always_comb begin
    nextState = state;
    stallC    = 1'b0;
    rdyC      = 1'b0;
    case (state)
      IDLE: begin
        if (isMd && !bus.flush) begin
          stallC    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          nextState = IDLE;
        end else begin
          stallC = 1'b1;
          if (lastIter) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        rdyC      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      opReg     <= '0;
      hi        <= '0;
      lo        <= '0;
      opDiv     <= 1'b0;
      negRes    <= 1'b0;
      resultReg <= '0;
      excReg    <= 1'b0;
    end else if (start) begin
      counter <= '0;
      opDiv   <= isDivIn;
      negRes  <= bus.data_inA[WIDTH-1] ^ bus.data_inB[WIDTH-1];
      opReg   <= isDivIn ? absB : absA;
      lo      <= isDivIn ? absA : absB;
      hi      <= '0;
    end else if ((state == RUN) && !bus.flush) begin
      counter <= counter + CW'(1);
      hi      <= hiStep;
      lo      <= loStep;
      if (finish) begin
        resultReg <= finalRes;
        excReg    <= finalExc;
      end
    end
  end

  // Reset gates stall so a held mul/div in D/X cannot stall during reset
  assign bus.stall      = stallC & reset;
  assign bus.result_rdy = rdyC;
  assign bus.result     = resultReg;
  assign bus.exception  = excReg;

endmodule

// File: tb/tb_x_multdiv_ctrl.sv
// Bench for x_multdiv_ctrl: vector table plus flush/reset sequences, D/X latch modelled from stall.
module tb_x_multdiv_ctrl;

  localparam logic [31:0] MUL  = 32'h0062_0018;
  localparam logic [31:0] DIV  = 32'h0062_001C;
  localparam logic [31:0] ADD  = 32'h0062_0020;
  localparam logic [31:0] FAKE = 32'h0800_0018;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  x_multdiv_ctrl_if #(.WIDTH(32)) bus ();

  x_multdiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expExc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sbq[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] lastRes = '0;
  logic        lastExc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  function automatic logic isMdF(input logic [31:0] i);
    return (i[31:27] == 5'b00000) && ((i[6:2] == 5'b00110) || (i[6:2] == 5'b00111));
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (i[6:2] == 5'b00110) begin
      p     = 64'(sa * sb);
      e.res = p[31:0];
      e.exc = !((p[63:31] == '0) || (p[63:31] == {33{1'b1}}));
    end else if (b == 32'h0) begin
      e.res = '0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      p     = 64'(sa / sb);
      e.res = p[31:0];
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Drive one instruction into D/X and follow it until the pipeline advances.
  task automatic runOne(input vec_t v, input string name);
    int   stallCnt;
    int   rdyInStall;
    bit   md;
    bit   done;
    exp_t e;
    md         = isMdF(v.instr);
    stallCnt   = 0;
    rdyInStall = 0;
    done       = 0;
    if (md) begin
      e.res = v.expRes;
      e.exc = v.expExc;
      sbq.push_back(e);
    end
    bus.instruction_in = v.instr;
    bus.data_inA       = v.a;
    bus.data_inB       = v.b;
    bus.flush          = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus.stall) begin
        stallCnt++;
        if (bus.result_rdy) rdyInStall++;
        @(posedge clk);
        #1;
        // Operands are already captured once RUN is entered
        if (stallCnt == 1) begin
          bus.data_inA = $urandom;
          bus.data_inB = $urandom;
        end
      end else begin
        done = 1;
        check({name, " stall cycles"}, stallCnt, md ? 33 : 0);
        check({name, " rdy during stall"}, rdyInStall, 0);
        check({name, " result_rdy"}, 32'(bus.result_rdy), 32'(md));
        if (md) begin
          if (sbq.size() == 0) begin
            check({name, " scoreboard empty"}, 32'(sbq.size()), 1);
          end else begin
            e = sbq.pop_front();
            check({name, " result"}, bus.result, e.res);
            check({name, " exception"}, 32'(bus.exception), 32'(e.exc));
            lastRes = e.res;
            lastExc = e.exc;
          end
        end else begin
          check({name, " result hold"}, bus.result, lastRes);
          check({name, " exception hold"}, 32'(bus.exception), 32'(lastExc));
        end
        @(posedge clk);
        #1;
      end
    end
    if (!done) check({name, " timeout"}, stallCnt, md ? 33 : 0);
  endtask

  initial begin
    exp_t        m;
    vec_t        v;
    int          stallCnt;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{MUL,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{DIV,  32'd5,          32'd0,         32'h0000_0000, 1'b1});
    vecs.push_back('{MUL,  32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{MUL,  32'd3,          32'd4,         32'd12,        1'b0});
    vecs.push_back('{MUL,  32'd5,          32'd6,         32'd30,        1'b0});
    vecs.push_back('{ADD,  32'd5,          32'd6,         32'd0,         1'b0});
    vecs.push_back('{FAKE, 32'd5,          32'd6,         32'd0,         1'b0});
    vecs.push_back('{MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0});
    vecs.push_back('{MUL,  32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
    vecs.push_back('{MUL,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{MUL,  32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1});
    vecs.push_back('{DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{DIV,  32'd7,          32'd7,         32'd1,         1'b0});
    for (int i = 0; i < 4; i++) begin
      ra = 32'($urandom_range(0, 65535));
      rb = 32'($urandom_range(1, 4095));
      if (i[0]) ra = ~ra + 1;
      if (i[1]) rb = ~rb + 1;
      v.instr = (i < 2) ? MUL : DIV;
      v.a     = ra;
      v.b     = rb;
      m       = model(v.instr, ra, rb);
      v.expRes = m.res;
      v.expExc = m.exc;
      vecs.push_back(v);
    end

    // Reset state, with a mul/div already sitting in D/X
    reset              = 1'b0;
    bus.instruction_in = MUL;
    bus.data_inA       = 32'd7;
    bus.data_inB       = 32'd9;
    bus.flush          = 1'b0;
    @(negedge clk);
    check("reset stall", 32'(bus.stall), 0);
    check("reset result_rdy", 32'(bus.result_rdy), 0);
    check("reset result", bus.result, 0);
    check("reset exception", 32'(bus.exception), 0);
    bus.instruction_in = NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) runOne(vecs[i], $sformatf("vec%0d", i));

    // Flush during the 10th RUN cycle
    bus.instruction_in = MUL;
    bus.data_inA       = 32'd9;
    bus.data_inB       = 32'd9;
    stallCnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.stall) stallCnt++;
      @(posedge clk);
      #1;
    end
    check("flush pre stall", stallCnt, 10);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush stall", 32'(bus.stall), 0);
    check("flush result_rdy", 32'(bus.result_rdy), 0);
    @(posedge clk);
    #1;
    bus.flush          = 1'b0;
    bus.instruction_in = NOP;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post flush stall", 32'(bus.stall), 0);
      check("post flush result_rdy", 32'(bus.result_rdy), 0);
      check("post flush result", bus.result, lastRes);
      check("post flush exception", 32'(bus.exception), 32'(lastExc));
      @(posedge clk);
      #1;
    end
    v = '{MUL, 32'hFFFF_FFF6, 32'd12, 32'hFFFF_FF88, 1'b0};
    runOne(v, "after flush");

    // Reset asserted mid-RUN
    bus.instruction_in = MUL;
    bus.data_inA       = 32'd11;
    bus.data_inB       = 32'd13;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrun reset stall", 32'(bus.stall), 0);
    check("midrun reset result_rdy", 32'(bus.result_rdy), 0);
    check("midrun reset result", bus.result, 0);
    check("midrun reset exception", 32'(bus.exception), 0);
    lastRes = '0;
    lastExc = 1'b0;
    bus.instruction_in = NOP;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post reset stall", 32'(bus.stall), 0);
      check("post reset result_rdy", 32'(bus.result_rdy), 0);
      @(posedge clk);
      #1;
    end
    v = '{DIV, 32'd144, 32'd12, 32'd12, 1'b0};
    runOne(v, "after reset");
    check("scoreboard drained", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/x_multdiv_ctrl.md
Name: x_multdiv_ctrl

Overview:
- Execute-stage consumer of the D/X latch contents. Decodes the instruction and operands held at the D/X outputs.
- For mul/div it runs a 32-cycle iterative signed multiply or divide. While the operation runs it raises stall, which the pipeline uses to hold the D/X write enable low.
- It then presents the result and exception flag for one non-stalled cycle so the X/M latch can capture them.
- Non-mul/div instructions pass through untouched: stall stays low and result_rdy stays low.

Parameters:
- WIDTH, 32, datapath and instruction width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- instruction_in  input  WIDTH  D/X instruction output.
- data_inA  input  WIDTH  D/X operand A (dividend / multiplicand).
- data_inB  input  WIDTH  D/X operand B (divisor / multiplier).
- flush  input  1  synchronous abort; aborts the in-flight operation.
- stall  output  1  hold D/X and earlier stages.
- result  output  WIDTH  mul/div result.
- result_rdy  output  1  result valid this cycle.
- exception  output  1  overflow / divide-by-zero flag, valid with result_rdy.

Behaviour:
- Decode:
  - is_md when instruction_in[31:27]==5'b00000 and instruction_in[6:2] is 5'b00110 (mul) or 5'b00111 (div).
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0.
  - result=0, exception=0, result_rdy=0.
  - All operand and partial registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stall = is_md (combinational) & ~flush.
  - On a clock edge with is_md & ~flush: latch |A|, |B|, op and result sign; counter=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - stall=1.
  - Each cycle performs one shift-add (mul) or one restoring shift-subtract (div) step; counter increments.
  - When counter==ITER-1, on the next edge: write result and exception, then go to DONE.
- DONE:
  - stall=0, result_rdy=1 for exactly one cycle.
  - At this edge the pipeline advances and D/X loads the next instruction. Next state is IDLE unconditionally.
  - A back-to-back mul/div is therefore detected in the following IDLE cycle.
- Latency and hold:
  - From the first cycle the mul/div is visible at D/X: 33 stall cycles (1 IDLE + 32 RUN), then 1 DONE cycle.
  - result and exception hold their values after DONE until the next completion.
  - result_rdy is 0 in every state except DONE.
- Multiply:
  - Signed; result = low 32 bits of the 64-bit product.
  - exception=1 if the product bits [63:31] are not all equal, i.e. the product does not fit in 32 bits signed.
- Divide:
  - Signed; quotient truncates toward zero. The remainder is discarded.
  - Divisor 0 → result=0, exception=1; still takes the full 32 cycles.
  - 0x80000000 / -1 → result=0x80000000, exception=1.
- Sign correction is applied when the result is written on the RUN→DONE edge.
- flush:
  - flush=1 in RUN or IDLE → next state IDLE, stall deasserted that cycle.
  - No result_rdy; result and exception are not updated.
  - flush in DONE is ignored; the result is already presented.
- Reset mid-operation aborts immediately to the reset values. No result_rdy follows.
- Operands are sampled only at IDLE→RUN. Changes on data_inA/B during RUN have no effect.

Test Plan:
- mul A=7, B=-3 → stall high for exactly 33 cycles, then one cycle with result_rdy=1, result=0xFFFFFFEB (-21), exception=0; stall=0 in that cycle.
- div A=100, B=-7 → result=0xFFFFFFF2 (-14), exception=0. Then div A=-100, B=7 → -14. Then div A=0x80000000, B=-1 → result=0x80000000, exception=1.
- div A=5, B=0 → full 33-cycle stall, result=0, exception=1. Then mul A=0x00010000, B=0x00010000 → result=0, exception=1.
- Back-to-back mul(3,4) then mul(5,6) with the D/X latch modelled from stall → results 12 then 30. Exactly one result_rdy pulse each, separated by 33 stall cycles. Non-mul add instruction → stall=0, result_rdy=0.
- flush asserted in RUN cycle 10 → stall=0 the following cycle, no result_rdy, result keeps its previous value. A new mul then completes normally.
- reset pulled low in RUN cycle 20 → stall, result_rdy, result and exception go to 0 immediately, without waiting for a clock edge. After reset is released with no mul/div in D/X, the block stays in IDLE.
